inst_fetch_unit: RTL and testbench

- Fetch stage sitting directly downstream of the program-counter register.
- Takes the current PC and runs an instruction-memory read using a req/ack handshake.
- Holds the fetched word and its PC in an output register for the decoder (valid/ready).
- Drives the PC register's advance enable and supports flush on branch/jump redirect.

---
 rtl/inst_fetch_unit_pkg.sv | 23 ++
 rtl/inst_fetch_unit_addr_check.sv | 35 +++
 rtl/inst_fetch_unit.sv | 135 +++++++++++++
 tb/tb_inst_fetch_unit.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package inst_fetch_unit_pkg;

    // Text-segment base: reset PC and lowest legal fetch address
    localparam logic [31:0] RESET_PC_DEF = 32'h00400000;

    // Default imem word-address width (2**11 words of instruction memory)
    localparam int ADDR_W_DEF = 11;

    // Instruction word width
    localparam int INST_W = 32;

    // Fetch controller states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2,
        ST_ERR  = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/inst_fetch_unit_addr_check.sv
// Legality test of a byte PC plus translation to an imem word address.
// Latency: purely combinational.
// Backpressure: none; the result is evaluated every cycle.
module fetch_addr_check
    import inst_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int          ADDR_W   = ADDR_W_DEF
) (
    input  logic [31:0]       pc_i,
    output logic              legal_o,
    output logic [ADDR_W-1:0] word_addr_o
);

    logic [31:0] offset;
    logic        aligned;
    logic        above_base;
    logic        in_range;

    // Byte offset into the text segment; only meaningful when above_base
    assign offset = pc_i - RESET_PC;

    // Classify the PC: word aligned, not below the base, and inside imem
    always_comb begin
        aligned    = (pc_i[1:0] == 2'b00);
        above_base = (pc_i >= RESET_PC);
        // Any offset bit at or above ADDR_W+2 means the word lies past imem
        in_range   = ((offset >> (ADDR_W + 2)) == 32'd0);
        legal_o    = aligned && above_base && in_range;
    end

    // Word address is the byte offset with the two byte-lane bits dropped
    assign word_addr_o = offset[ADDR_W+1:2];

endmodule

// File: rtl/inst_fetch_unit.sv
// Fetch stage: latches the PC, reads imem over req/ack, presents the word to decode.
// Latency: one cycle from the ack cycle to inst_valid; one instruction per two cycles at best.
// Backpressure: inst_ready low holds the output register and stalls further requests.
module inst_fetch_unit
    import inst_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int          ADDR_W   = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       pc_in,
    output logic              pc_ena,
    input  logic              flush,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [31:0]       inst_out,
    output logic [31:0]       inst_pc,
    output logic              fetch_err
);

    fetch_state_e        state_q;
    logic [31:0]         pc_lat_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                imem_req_q;
    logic                inst_valid_q;
    logic [INST_W-1:0]   inst_out_q;
    logic [31:0]         inst_pc_q;
    logic                fetch_err_q;

    logic                pc_legal;
    logic [ADDR_W-1:0]   pc_word_addr;
    logic                ack_take;

    // The check always looks at pc_in: it is only consumed on the edges
    // where pc_in is latched into pc_lat (from IDLE, or HOLD on hand-off).
    fetch_addr_check #(
        .RESET_PC (RESET_PC),
        .ADDR_W   (ADDR_W)
    ) u_addr_check (
        .pc_i        (pc_in),
        .legal_o     (pc_legal),
        .word_addr_o (pc_word_addr)
    );

    // An ack only counts in REQ, and never when reset or a redirect is pending
    assign ack_take = (state_q == ST_REQ) && imem_ack && !flush && !rst;

    // Advance the PC register exactly in the cycle the fetched word is captured
    assign pc_ena = ack_take;

    // Fetch controller; state and all registered outputs move on the falling edge
    always_ff @(negedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            pc_lat_q     <= RESET_PC;
            addr_q       <= '0;
            imem_req_q   <= 1'b0;
            inst_valid_q <= 1'b0;
            inst_out_q   <= '0;
            inst_pc_q    <= RESET_PC;
            fetch_err_q  <= 1'b0;
        end else if (flush) begin
            // Redirect: drop whatever is held or in flight; the new PC is
            // picked up from IDLE on the following edge.
            state_q      <= ST_IDLE;
            imem_req_q   <= 1'b0;
            inst_valid_q <= 1'b0;
            fetch_err_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    pc_lat_q <= pc_in;
                    addr_q   <= pc_word_addr;
                    if (pc_legal) begin
                        state_q    <= ST_REQ;
                        imem_req_q <= 1'b1;
                    end else begin
                        state_q     <= ST_ERR;
                        fetch_err_q <= 1'b1;
                    end
                end
                ST_REQ: begin
                    // Address and request stay put until the memory answers
                    if (imem_ack) begin
                        inst_out_q   <= imem_rdata;
                        inst_pc_q    <= pc_lat_q;
                        inst_valid_q <= 1'b1;
                        imem_req_q   <= 1'b0;
                        state_q      <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    // pc_in was already advanced by the pc_ena pulse, so
                    // the hand-off edge can launch the next fetch directly.
                    if (inst_ready) begin
                        inst_valid_q <= 1'b0;
                        pc_lat_q     <= pc_in;
                        addr_q       <= pc_word_addr;
                        if (pc_legal) begin
                            state_q    <= ST_REQ;
                            imem_req_q <= 1'b1;
                        end else begin
                            state_q     <= ST_ERR;
                            fetch_err_q <= 1'b1;
                        end
                    end
                end
                ST_ERR: begin
                    // Parked until reset or a redirect
                    imem_req_q   <= 1'b0;
                    inst_valid_q <= 1'b0;
                    fetch_err_q  <= 1'b1;
                end
                default: begin
                    state_q      <= ST_IDLE;
                    imem_req_q   <= 1'b0;
                    inst_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req   = imem_req_q;
    assign imem_addr  = addr_q;
    assign inst_valid = inst_valid_q;
    assign inst_out   = inst_out_q;
    assign inst_pc    = inst_pc_q;
    assign fetch_err  = fetch_err_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit with a PC-register model and imem model.
// DUT state moves on the falling edge; inputs change 1 time unit after it.
// Fetched words are queued as expected on ack and checked on decoder hand-off.
module tb_inst_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h00400000;
    localparam int          ADDR_W   = 11;

    typedef struct packed {
        logic [31:0] dat;
        logic [31:0] pc;
    } exp_t;

    logic              clk;
    logic              rst;
    logic [31:0]       pc_in;
    logic              pc_ena;
    logic              flush;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [31:0]       imem_rdata;
    logic              inst_valid;
    logic              inst_ready;
    logic [31:0]       inst_out;
    logic [31:0]       inst_pc;
    logic              fetch_err;

    int   n_checks;
    int   n_pass;
    int   ena_cnt;
    int   req_cnt;
    int   mem_wait;
    logic mem_en;
    logic last_ena;
    exp_t sb[$];

    inst_fetch_unit #(
        .RESET_PC (RESET_PC),
        .ADDR_W   (ADDR_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pc_in      (pc_in),
        .pc_ena     (pc_ena),
        .flush      (flush),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .inst_out   (inst_out),
        .inst_pc    (inst_pc),
        .fetch_err  (fetch_err)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    // Instruction memory contents as a function of byte PC
    function automatic logic [31:0] mem_word(input logic [31:0] pc);
        return 32'h2008000A ^ ((pc - RESET_PC) << 8);
    endfunction

    // One clock: memory model, scoreboard push/pop, edge, PC-register model
    task automatic step();
        logic ena;
        exp_t e;
        if (mem_en) begin
            if (imem_req && req_cnt == mem_wait) begin
                imem_ack   = 1'b1;
                imem_rdata = mem_word(pc_in);
                req_cnt    = 0;
            end else if (imem_req) begin
                imem_ack = 1'b0;
                req_cnt++;
            end else begin
                imem_ack = 1'b0;
                req_cnt  = 0;
            end
        end
        #2;
        ena      = pc_ena;
        last_ena = ena;
        if (ena) ena_cnt++;
        if (imem_req && imem_ack && !flush && !rst)
            sb.push_back('{dat: imem_rdata, pc: pc_in});
        if (inst_valid && inst_ready && !flush && !rst) begin
            n_checks++;
            if (sb.size() == 0) begin
                $display("FAIL sb_pop: got inst %h pc %h, expected no instruction", inst_out, inst_pc);
            end else begin
                e = sb.pop_front();
                if (inst_out !== e.dat || inst_pc !== e.pc)
                    $display("FAIL sb_pop: got inst %h pc %h, expected inst %h pc %h",
                             inst_out, inst_pc, e.dat, e.pc);
                else
                    n_pass++;
            end
        end
        @(negedge clk);
        #1;
        if (rst) pc_in = RESET_PC;
        else if (ena) pc_in = pc_in + 32'd4;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        flush      = 1'b0;
        imem_ack   = 1'b0;
        inst_ready = 1'b1;
        step();
        step();
        rst     = 1'b0;
        sb.delete();
        req_cnt = 0;
        ena_cnt = 0;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        imem_ack = 1'b1;
        step();
        step();
        n_checks++;
        if (imem_req !== 1'b0 || inst_valid !== 1'b0 || fetch_err !== 1'b0 || pc_ena !== 1'b0)
            $display("FAIL reset_ctl: req %b valid %b err %b ena %b, expected all 0",
                     imem_req, inst_valid, fetch_err, pc_ena);
        else n_pass++;
        n_checks++;
        if (inst_out !== 32'h0 || inst_pc !== RESET_PC)
            $display("FAIL reset_dat: inst_out %h inst_pc %h, expected 00000000 %h", inst_out, inst_pc, RESET_PC);
        else n_pass++;
        imem_ack = 1'b0;
        rst      = 1'b0;
    endtask

    task automatic test_zero_wait();
        do_reset();
        mem_en = 1'b1; mem_wait = 0; inst_ready = 1'b1;
        step();
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 11'd0)
            $display("FAIL zw_first_req: req %b addr %0d, expected 1 0", imem_req, imem_addr);
        else n_pass++;
        step();
        n_checks++;
        if (inst_valid !== 1'b1 || inst_pc !== RESET_PC || inst_out !== mem_word(RESET_PC) || ena_cnt != 1)
            $display("FAIL zw_first_inst: valid %b pc %h inst %h ena_cnt %0d, expected 1 %h %h 1",
                     inst_valid, inst_pc, inst_out, ena_cnt, RESET_PC, mem_word(RESET_PC));
        else n_pass++;
        step();
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 11'd1 || inst_valid !== 1'b0)
            $display("FAIL zw_second_req: req %b addr %0d valid %b, expected 1 1 0", imem_req, imem_addr, inst_valid);
        else n_pass++;
        for (int i = 0; i < 8; i++) step();
        n_checks++;
        if (ena_cnt != 5 || pc_in !== 32'h00400014 || imem_addr !== 11'd5 || imem_req !== 1'b1)
            $display("FAIL zw_throughput: ena_cnt %0d pc %h addr %0d req %b, expected 5 00400014 5 1",
                     ena_cnt, pc_in, imem_addr, imem_req);
        else n_pass++;
    endtask

    task automatic test_wait_states();
        do_reset();
        mem_en = 1'b1; mem_wait = 3; inst_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            n_checks++;
            if (imem_req !== 1'b1 || imem_addr !== 11'd0 || last_ena !== 1'b0)
                $display("FAIL ws_hold_req%0d: req %b addr %0d ena %b, expected 1 0 0", i, imem_req, imem_addr, last_ena);
            else n_pass++;
        end
        step();
        n_checks++;
        if (last_ena !== 1'b1 || inst_valid !== 1'b1 || inst_out !== 32'h2008000A)
            $display("FAIL ws_ack: ena %b valid %b inst %h, expected 1 1 2008000a", last_ena, inst_valid, inst_out);
        else n_pass++;
        step();
        mem_wait = 0;
    endtask

    task automatic test_stall();
        do_reset();
        mem_en = 1'b1; mem_wait = 0; inst_ready = 1'b0;
        step();
        step();
        for (int i = 0; i < 5; i++) begin
            step();
            n_checks++;
            if (inst_valid !== 1'b1 || inst_out !== mem_word(RESET_PC) || inst_pc !== RESET_PC ||
                imem_req !== 1'b0 || last_ena !== 1'b0)
                $display("FAIL stall%0d: valid %b inst %h pc %h req %b ena %b, expected 1 %h %h 0 0",
                         i, inst_valid, inst_out, inst_pc, imem_req, last_ena, mem_word(RESET_PC), RESET_PC);
            else n_pass++;
        end
        inst_ready = 1'b1;
        step();
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 11'd1 || inst_valid !== 1'b0)
            $display("FAIL stall_release: req %b addr %0d valid %b, expected 1 1 0", imem_req, imem_addr, inst_valid);
        else n_pass++;
    endtask

    task automatic test_flush_ack();
        do_reset();
        mem_en = 1'b1; mem_wait = 0; inst_ready = 1'b1;
        step();
        flush = 1'b1;
        step();
        n_checks++;
        if (last_ena !== 1'b0 || inst_valid !== 1'b0 || imem_req !== 1'b0)
            $display("FAIL flush_ack: ena %b valid %b req %b, expected 0 0 0", last_ena, inst_valid, imem_req);
        else n_pass++;
        flush = 1'b0;
        pc_in = 32'h00400040;
        step();
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 11'd16)
            $display("FAIL flush_redirect: req %b addr %0d, expected 1 16", imem_req, imem_addr);
        else n_pass++;
        step();
        n_checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'h00400040)
            $display("FAIL flush_refetch: valid %b pc %h, expected 1 00400040", inst_valid, inst_pc);
        else n_pass++;
        step();
    endtask

    task automatic test_illegal();
        logic [31:0] pcs [5];
        logic        ok  [5];
        pcs[0] = 32'h00400002; ok[0] = 1'b0;
        pcs[1] = 32'h00000000; ok[1] = 1'b0;
        pcs[2] = 32'h003FFFFC; ok[2] = 1'b0;
        pcs[3] = 32'h00402000; ok[3] = 1'b0;
        pcs[4] = 32'h00401FFC; ok[4] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            do_reset();
            mem_en = 1'b0; imem_ack = 1'b0;
            pc_in = pcs[i];
            step();
            n_checks++;
            if (fetch_err !== !ok[i] || imem_req !== ok[i] || (ok[i] && imem_addr !== 11'd2047))
                $display("FAIL legal_%h: err %b req %b addr %0d, expected err %b req %b",
                         pcs[i], fetch_err, imem_req, imem_addr, !ok[i], ok[i]);
            else n_pass++;
        end
        do_reset();
        mem_en = 1'b0; imem_ack = 1'b0;
        pc_in = 32'h00400002;
        for (int i = 0; i < 4; i++) begin
            step();
            n_checks++;
            if (fetch_err !== 1'b1 || imem_req !== 1'b0 || inst_valid !== 1'b0)
                $display("FAIL err_sticky%0d: err %b req %b valid %b, expected 1 0 0", i, fetch_err, imem_req, inst_valid);
            else n_pass++;
        end
        flush = 1'b1;
        pc_in = 32'h00400008;
        step();
        n_checks++;
        if (fetch_err !== 1'b0 || imem_req !== 1'b0)
            $display("FAIL err_flush: err %b req %b, expected 0 0", fetch_err, imem_req);
        else n_pass++;
        flush = 1'b0;
        step();
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 11'd2 || fetch_err !== 1'b0)
            $display("FAIL err_refetch: req %b addr %0d err %b, expected 1 2 0", imem_req, imem_addr, fetch_err);
        else n_pass++;
    endtask

    task automatic test_reset_in_req();
        do_reset();
        mem_en = 1'b0; inst_ready = 1'b1; imem_ack = 1'b0;
        step();
        imem_ack = 1'b1; imem_rdata = 32'h11111111;
        step();
        imem_ack = 1'b0;
        step();
        step();
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 11'd1)
            $display("FAIL rr_pending: req %b addr %0d, expected 1 1", imem_req, imem_addr);
        else n_pass++;
        rst = 1'b1;
        step();
        n_checks++;
        if (imem_req !== 1'b0 || inst_valid !== 1'b0 || fetch_err !== 1'b0 ||
            inst_out !== 32'h0 || inst_pc !== RESET_PC)
            $display("FAIL rr_reset: req %b valid %b err %b inst %h pc %h, expected 0 0 0 00000000 %h",
                     imem_req, inst_valid, fetch_err, inst_out, inst_pc, RESET_PC);
        else n_pass++;
        rst = 1'b0;
        imem_ack = 1'b1; imem_rdata = 32'hDEADBEEF;
        step();
        n_checks++;
        if (last_ena !== 1'b0 || inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 11'd0)
            $display("FAIL rr_late_ack: ena %b valid %b req %b addr %0d, expected 0 0 1 0",
                     last_ena, inst_valid, imem_req, imem_addr);
        else n_pass++;
        step();
        imem_ack = 1'b0;
        n_checks++;
        if (inst_valid !== 1'b1 || inst_pc !== RESET_PC || inst_out !== 32'hDEADBEEF)
            $display("FAIL rr_restart: valid %b pc %h inst %h, expected 1 %h deadbeef",
                     inst_valid, inst_pc, inst_out, RESET_PC);
        else n_pass++;
        step();
    endtask

    initial begin
        n_checks = 0; n_pass = 0; ena_cnt = 0; req_cnt = 0; mem_wait = 0;
        mem_en = 1'b0; last_ena = 1'b0;
        rst = 1'b1; flush = 1'b0; pc_in = RESET_PC;
        imem_ack = 1'b0; imem_rdata = 32'h0; inst_ready = 1'b0;
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_stall();
        test_flush_ack();
        test_illegal();
        test_reset_in_req();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
